// File: rtl/logic_resp_checker.sv
// ============================================================================
// Module  : logic_resp_checker
// Brief   : Checks (a, b, c) samples from a two-input gate against the
//           expected result of a selected function. Counts passes and
//           fails, tracks {a,b} coverage, and flags done once all four
//           combinations have been seen. If LOGIC_CHK_STOP_ON_FAIL_EN is
//           defined, the first mismatch also ends the run.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module logic_resp_checker #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_a,
  input  logic             in_b,
  input  logic             in_c,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [3:0]       cov_mask,
  output logic             first_fail_vld,
  output logic [1:0]       first_fail_idx,
  output logic             busy,
  output logic             done,
  output logic             all_pass
);

  localparam logic [1:0]       S_IDLE  = 2'd0;
  localparam logic [1:0]       S_RUN   = 2'd1;
  localparam logic [1:0]       S_DONE  = 2'd2;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state_q, state_d;
  logic [2:0]       op_q;
  logic [CNT_W-1:0] pass_q, fail_q;
  logic [3:0]       cov_q, cov_d;
  logic             ffv_q;
  logic [1:0]       ffi_q;
  logic [1:0]       idx;
  logic             exp_c, match, accept, stop_hit;

  assign idx    = {in_a, in_b};
  assign match  = (in_c == exp_c);
  assign accept = in_valid & in_ready;
  assign cov_d  = cov_q | (4'b0001 << idx);

`ifdef LOGIC_CHK_STOP_ON_FAIL_EN
  assign stop_hit = accept & ~match;
`else
  assign stop_hit = 1'b0;
`endif

  always_comb begin
    exp_c = 1'b0;
    case (op_q)
      3'd0:    exp_c = in_a & in_b;
      3'd1:    exp_c = in_a | in_b;
      3'd2:    exp_c = in_a ^ in_b;
      3'd3:    exp_c = ~(in_a & in_b);
      3'd4:    exp_c = ~(in_a | in_b);
      3'd5:    exp_c = ~(in_a ^ in_b);
      3'd6:    exp_c = ~in_a;
      default: exp_c = in_a;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic; start wins from any state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (start) state_d = S_RUN;
      S_RUN: begin
        if (start)
          state_d = S_RUN;
        else if (accept && ((cov_d == 4'hF) || stop_hit))
          state_d = S_DONE;
      end
      S_DONE: if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from state
  always_comb begin
    in_ready = (state_q == S_RUN) && !start;
    busy     = (state_q == S_RUN);
    done     = (state_q == S_DONE);
    all_pass = (state_q == S_DONE) && (fail_q == '0);
  end

  always_ff @(posedge clk) begin
    if (rst || start) begin
      pass_q <= '0;
      fail_q <= '0;
      cov_q  <= 4'h0;
      ffv_q  <= 1'b0;
      ffi_q  <= 2'b00;
      if (rst) op_q <= 3'd0;
      else     op_q <= op;
    end else if (accept) begin
      cov_q <= cov_d;
      if (match) begin
        if (pass_q != CNT_MAX) pass_q <= pass_q + 1'b1;
      end else begin
        if (fail_q != CNT_MAX) fail_q <= fail_q + 1'b1;
        if (!ffv_q) begin
          ffv_q <= 1'b1;
          ffi_q <= idx;
        end
      end
    end
  end

  assign pass_cnt       = pass_q;
  assign fail_cnt       = fail_q;
  assign cov_mask       = cov_q;
  assign first_fail_vld = ffv_q;
  assign first_fail_idx = ffi_q;

endmodule

`default_nettype wire

// File: tb/tb_logic_resp_checker.sv
// ============================================================================
// Module  : tb_logic_resp_checker
// Brief   : Runs directed vectors into two checkers (CNT_W=8 and CNT_W=2).
//           A truth-table model is compared against both every cycle.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_logic_resp_checker;

  logic clk = 1'b0;
  logic rst = 1'b1, start = 1'b0, in_valid = 1'b0;
  logic in_a = 1'b0, in_b = 1'b0, in_c = 1'b0;
  logic [2:0] op = 3'd0;

  logic       rdy8, ffv8, busy8, done8, ap8;
  logic [7:0] pass8, fail8;
  logic [3:0] cov8;
  logic [1:0] ffi8;
  logic       rdy2, ffv2, busy2, done2, ap2;
  logic [1:0] pass2, fail2;
  logic [3:0] cov2;
  logic [1:0] ffi2;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  logic_resp_checker #(.CNT_W(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start), .op(op), .in_valid(in_valid),
    .in_ready(rdy8), .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .pass_cnt(pass8), .fail_cnt(fail8), .cov_mask(cov8),
    .first_fail_vld(ffv8), .first_fail_idx(ffi8),
    .busy(busy8), .done(done8), .all_pass(ap8)
  );

  logic_resp_checker #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start), .op(op), .in_valid(in_valid),
    .in_ready(rdy2), .in_a(in_a), .in_b(in_b), .in_c(in_c),
    .pass_cnt(pass2), .fail_cnt(fail2), .cov_mask(cov2),
    .first_fail_vld(ffv2), .first_fail_idx(ffi2),
    .busy(busy2), .done(done2), .all_pass(ap2)
  );

  // Reference model: phase 0 idle, 1 running, 2 finished
  typedef struct {
    int       phase;
    int       op;
    int       pass;
    int       fail;
    bit [3:0] seen;
    bit       ffv;
    int       ffi;
  } mdl_t;

  mdl_t m[2];
  int   cmax[2] = '{255, 3};

  // Truth tables indexed by {a,b}
  function automatic bit gate(int f, bit a, bit b);
    bit [3:0] tt[8];
    tt = '{4'b1000, 4'b1110, 4'b0110, 4'b0111, 4'b0001, 4'b1001, 4'b0011, 4'b1100};
    return tt[f][{a, b}];
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m[k] = '{0, 0, 0, 0, 4'h0, 1'b0, 0};
      end else if (start) begin
        m[k] = '{1, int'(op), 0, 0, 4'h0, 1'b0, 0};
      end else if (m[k].phase == 1 && in_valid) begin
        if (in_c == gate(m[k].op, in_a, in_b)) begin
          if (m[k].pass < cmax[k]) m[k].pass++;
        end else begin
          if (m[k].fail < cmax[k]) m[k].fail++;
          if (!m[k].ffv) begin
            m[k].ffv = 1'b1;
            m[k].ffi = 2 * int'(in_a) + int'(in_b);
          end
`ifdef LOGIC_CHK_STOP_ON_FAIL_EN
          m[k].phase = 2;
`endif
        end
        m[k].seen[2 * int'(in_a) + int'(in_b)] = 1'b1;
        if (&m[k].seen) m[k].phase = 2;
      end
    end
  end

  task automatic chk(input string name, input int k, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d at %0t: got %0h expected %0h", name, k, $time, got, exp);
    end
  endtask

  task automatic chk_dut(input int k, input logic rdy, input logic [7:0] pc, input logic [7:0] fc,
                         input logic [3:0] cv, input logic fv, input logic [1:0] fi,
                         input logic bz, input logic dn, input logic ap);
    chk("in_ready", k, 32'(rdy), 32'(m[k].phase == 1 && !start));
    chk("busy", k, 32'(bz), 32'(m[k].phase == 1));
    chk("done", k, 32'(dn), 32'(m[k].phase == 2));
    chk("all_pass", k, 32'(ap), 32'(m[k].phase == 2 && m[k].fail == 0));
    chk("pass_cnt", k, 32'(pc), 32'(m[k].pass));
    chk("fail_cnt", k, 32'(fc), 32'(m[k].fail));
    chk("cov_mask", k, 32'(cv), 32'(m[k].seen));
    chk("ff_vld", k, 32'(fv), 32'(m[k].ffv));
    chk("ff_idx", k, 32'(fi), 32'(m[k].ffi));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk_dut(0, rdy8, pass8, fail8, cov8, ffv8, ffi8, busy8, done8, ap8);
      chk_dut(1, rdy2, {6'b0, pass2}, {6'b0, fail2}, cov2, ffv2, ffi2, busy2, done2, ap2);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [2:0] f);
    start = 1'b1;
    op    = f;
    step();
    start = 1'b0;
    op    = ~f;
  endtask

  task automatic smp(input logic a, input logic b, input logic c);
    in_valid = 1'b1;
    in_a = a; in_b = b; in_c = c;
    step();
    in_valid = 1'b0;
  endtask

  initial begin
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    repeat (3) step();
    chk("idle_rdy", 0, 32'(rdy8), 32'd0);
    chk("idle_done", 0, 32'(done8), 32'd0);

    // AND sweep, all correct, in_valid held across samples
    do_start(3'd0);
    in_valid = 1'b1;
    in_a = 0; in_b = 0; in_c = 0; step();
    in_a = 1; in_b = 0; in_c = 0; step();
    in_a = 0; in_b = 1; in_c = 0; step();
    in_a = 1; in_b = 1; in_c = 1; step();
    chk("and_pass", 0, 32'(pass8), 32'd4);
    chk("and_cov", 0, 32'(cov8), 32'hF);
    chk("and_allpass", 0, 32'(ap8), 32'd1);
    chk("and_rdy", 0, 32'(rdy8), 32'd0);
    in_valid = 1'b0;
    step();

    // XOR with one mismatch at {1,0}
    do_start(3'd2);
    smp(0, 0, 0); smp(1, 0, 0); smp(1, 0, 1); smp(0, 1, 1); smp(1, 1, 0);
    chk("xor_ffidx", 0, 32'(ffi8), 32'd2);
    chk("xor_ffvld", 0, 32'(ffv8), 32'd1);
    chk("xor_done", 0, 32'(done8), 32'd1);
    chk("xor_allpass", 0, 32'(ap8), 32'd0);
    chk("xor_fail", 0, 32'(fail8), 32'd1);
`ifdef LOGIC_CHK_STOP_ON_FAIL_EN
    chk("xor_pass", 0, 32'(pass8), 32'd1);
    chk("xor_cov", 0, 32'(cov8), 32'h5);
`else
    chk("xor_pass", 0, 32'(pass8), 32'd4);
    chk("xor_cov", 0, 32'(cov8), 32'hF);
`endif

    // BUF_A: repeated {1,1} saturates the 2-bit counter
    do_start(3'd7);
    repeat (6) smp(1, 1, 1);
    smp(0, 0, 0); smp(0, 1, 0);
    chk("buf_notdone", 1, 32'(done2), 32'd0);
    smp(1, 0, 1);
    chk("buf_sat", 1, 32'(pass2), 32'd3);
    chk("buf_done", 1, 32'(done2), 32'd1);
    chk("buf_pass8", 0, 32'(pass8), 32'd9);

    // Restart in RUN with a sample presented during start
    do_start(3'd0);
    smp(0, 0, 0); smp(0, 1, 0);
    in_valid = 1'b1; in_a = 1; in_b = 1; in_c = 1;
    start = 1'b1; op = 3'd0;
    step();
    start = 1'b0; in_valid = 1'b0;
    chk("rst_pass", 0, 32'(pass8), 32'd0);
    chk("rst_cov", 0, 32'(cov8), 32'd0);
    chk("rst_busy", 0, 32'(busy8), 32'd1);

    // Reset mid-run, then a clean NAND check
    do_start(3'd1);
    smp(0, 0, 0); smp(0, 1, 1);
    chk("mid_cov", 0, 32'(cov8), 32'h3);
    rst = 1'b1; in_valid = 1'b1;
    step();
    rst = 1'b0; in_valid = 1'b0;
    chk("mid_cov0", 0, 32'(cov8), 32'd0);
    chk("mid_busy0", 0, 32'(busy8), 32'd0);
    do_start(3'd3);
    smp(0, 0, 1); smp(0, 1, 1); smp(1, 0, 1); smp(1, 1, 0);
    chk("nand_pass", 0, 32'(pass8), 32'd4);
    chk("nand_allpass", 0, 32'(ap8), 32'd1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/logic_resp_checker.md
Name: logic_resp_checker

Overview:
- Synthesizable response checker for the two-input logic-gate blocks: the receiving end of the a/b stimulus sweep.
- Accepts one (a, b, observed c) sample per handshake. Compares c against the expected result of a selected gate function.
- Counts passes and fails, tracks coverage of the four input combinations, and reports done once all four have been seen.
- Sits beside the gate DUT in on-chip self-test and in bench wrappers. It replaces $monitor-style eyeballing.

Parameters:
- CNT_W, 8, width of the pass and fail counters. Legal range 2..16.

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse; latches op, clears results, enters RUN.
- op  input  3  gate under check. 0 AND, 1 OR, 2 XOR, 3 NAND, 4 NOR, 5 XNOR, 6 NOT_A (c = ~a), 7 BUF_A (c = a).
- in_valid  input  1  a sample is presented on in_a/in_b/in_c.
- in_ready  output  1  the checker accepts a sample this cycle.
- in_a  input  1  stimulus input a applied to the DUT.
- in_b  input  1  stimulus input b applied to the DUT.
- in_c  input  1  DUT output observed for (in_a, in_b).
- pass_cnt  output  CNT_W  number of matching samples.
- fail_cnt  output  CNT_W  number of mismatching samples.
- cov_mask  output  4  bit {a,b} is set once that combination has been accepted.
- first_fail_vld  output  1  a mismatch has been recorded.
- first_fail_idx  output  2  {a,b} of the first mismatch.
- busy  output  1  state is RUN.
- done  output  1  state is DONE.
- all_pass  output  1  done and fail_cnt == 0.

Behaviour:
- Reset (rst high at a clock edge): state IDLE. All outputs 0: in_ready, pass_cnt, fail_cnt, cov_mask, first_fail_vld, first_fail_idx, busy, done, all_pass.
- rst has priority over every other input. Reset in the middle of RUN discards all results.
- States: IDLE, RUN, DONE.
- IDLE --start--> RUN.
- RUN --coverage complete--> DONE.
- DONE --start--> RUN.
- start while in RUN restarts the check: results are cleared and the state stays RUN.
- On start, at that edge:
  - op_q <= op.
  - Counters, cov_mask, first_fail_vld and first_fail_idx are cleared.
  - Any sample presented in the same cycle is ignored.
- op is sampled only at start. Changes to op during RUN have no effect.
- in_ready = 1 only in RUN, and not in a cycle where start is high. It is combinational from state and start.
- Accept = in_valid & in_ready. Non-accepted cycles change nothing.
- Expected value exp = f(op_q, in_a, in_b). match = (in_c == exp).
- On an accepting edge:
  - pass_cnt increments on a match; otherwise fail_cnt increments.
  - cov_mask[{in_a,in_b}] <= 1.
  - On a mismatch with first_fail_vld == 0: first_fail_vld <= 1 and first_fail_idx <= {in_a,in_b}. Later mismatches do not overwrite them.
- Latency: results are visible the cycle after the accepting edge.
- Counters saturate at 2^CNT_W-1 and never wrap.
- Repeated combinations are counted every time they are accepted.
- DONE entry: at the accepting edge where cov_mask | onehot({in_a,in_b}) == 4'hF. That final sample is counted.
- In DONE:
  - in_ready = 0 and all results hold.
  - done = 1 and busy = 0.
  - all_pass = (fail_cnt == 0).
- busy = 1 exactly in RUN.
- For op 6 and 7, b is don't-care for the expected value. Coverage still requires all four {a,b} combinations.

Optional Feature:
- Macro: LOGIC_CHK_STOP_ON_FAIL_EN.
- Defined: the accepting edge of the first mismatch moves RUN->DONE. That mismatch is counted and recorded; cov_mask may be incomplete.
- Undefined: a mismatch never ends RUN; DONE is reached only on full coverage.

Test Plan:
- Reset, then idle 3 cycles -> all outputs 0, in_ready 0, state IDLE.
- start with op=0 (AND); samples (0,0,0), (1,0,0), (0,1,0), (1,1,1) back-to-back with in_valid held -> pass_cnt=4, fail_cnt=0, cov_mask=F, done=1 and all_pass=1 the cycle after the 4th sample; in_ready=0 afterwards.
- start with op=2 (XOR); samples (0,0,0), (1,0,0), (1,0,1), (0,1,1), (1,1,0) -> pass_cnt=4, fail_cnt=1, first_fail_idx=2'b10, first_fail_vld=1, done=1, all_pass=0.
  - Same scenario with LOGIC_CHK_STOP_ON_FAIL_EN defined -> done=1 after the 2nd sample, cov_mask=4'b0101.
- CNT_W=2, op=7; sample (1,1,1) presented 6 times, then (0,0,0), (0,1,0), (1,0,1) -> pass_cnt saturates at 3, fail_cnt=0, done after the 9th sample.
- start pulsed in RUN after 2 samples, with in_valid high in the start cycle -> counters and cov_mask are 0 the next cycle; the start-cycle sample is not counted.
- rst asserted mid-RUN with cov_mask=4'b0011 -> next cycle: IDLE, all outputs 0; a following start with op=3 (NAND) checks cleanly.
